// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte with odd parity and stop bit, then checks the device ACK.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus released, waiting for tx_valid
// INHIBIT   | ps2_clk held low; start bit asserted on the final cycle
// REQ       | clock released, data held low, waiting for first device clock
// SHIFT     | data, parity, stop bits driven one per falling edge
// ACK       | data released, sample device ACK on the next falling edge
// WAIT_IDLE | wait for both lines high before reporting done
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   sync_clk, sync_data, sync_clk_prev, fall;

  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic             data_oe_q;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             timed_state, timeout;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync      <= '1;
      data_sync     <= '1;
      sync_clk_prev <= 1'b1;
    end else begin
      clk_sync[0]  <= ps2_clk_in;
      data_sync[0] <= ps2_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      sync_clk_prev <= sync_clk;
    end
  end

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign fall      = sync_clk_prev & ~sync_clk;

  assign timed_state = (state == S_REQ) || (state == S_SHIFT) ||
                       (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout     = timed_state && (to_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (tx_valid) state_next = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == '0) state_next = S_REQ;
      S_REQ: begin
        if (timeout)   state_next = S_IDLE;
        else if (fall) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (timeout)                      state_next = S_IDLE;
        else if (fall && bit_cnt == 4'd9) state_next = S_ACK;
      end
      S_ACK: begin
        if (timeout)   state_next = S_IDLE;
        else if (fall) state_next = sync_data ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (timeout)                    state_next = S_IDLE;
        else if (sync_clk && sync_data) state_next = S_IDLE;
      end
      default:     state_next = S_IDLE;
    endcase
  end

  // Timers are down-counters; the timeout is loaded on the INHIBIT->REQ step
  // and runs uninterrupted through WAIT_IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= '0;
      bit_cnt   <= '0;
      data_oe_q <= 1'b0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          data_oe_q <= 1'b0;
          if (tx_valid) begin
            frame   <= {1'b1, ~^tx_data, tx_data};
            bit_cnt <= '0;
            inh_cnt <= INH_LAST;
            to_cnt  <= '0;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt != '0) inh_cnt <= inh_cnt - 1'b1;
          else               to_cnt  <= TO_LAST;
        end
        default: begin
          if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
          if (timeout) begin
            data_oe_q <= 1'b0;
          end else if (fall && state == S_REQ) begin
            data_oe_q <= ~frame[0];
            bit_cnt   <= 4'd1;
          end else if (fall && state == S_SHIFT) begin
            data_oe_q <= ~frame[bit_cnt];
            bit_cnt   <= bit_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    tx_ready    = (state == S_IDLE);
    busy        = (state != S_IDLE);
    done        = 1'b0;
    error       = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (inh_cnt == '0);
      end
      S_REQ: begin
        ps2_data_oe = ~timeout;
        error       = timeout;
      end
      S_SHIFT: begin
        ps2_data_oe = data_oe_q & ~timeout;
        error       = timeout;
      end
      S_ACK:       error = timeout | (fall & sync_data);
      S_WAIT_IDLE: begin
        error = timeout;
        done  = ~timeout & sync_clk & sync_data;
      end
      default: ;
    endcase
  end

endmodule
